// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD host command sequencer.
// Holds the sequencer state encoding and the LCD command codes.
package lcd_pkg;

  localparam int PIX_TOTAL = 64;
  localparam int CMD_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    GAP,
    WAIT_DONE,
    FINISH
  } state_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE       = 4'd0,
    CMD_SHIFT_UP    = 4'd1,
    CMD_SHIFT_DOWN  = 4'd2,
    CMD_SHIFT_LEFT  = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_MAX         = 4'd5,
    CMD_MIN         = 4'd6,
    CMD_AVG         = 4'd7,
    CMD_ROTATE_L    = 4'd8,
    CMD_ROTATE_R    = 4'd9,
    CMD_MIRROR_X    = 4'd10,
    CMD_MIRROR_Y    = 4'd11
  } cmd_t;

endpackage

// File: rtl/lcd_host_seq_iram_mon.sv
// Pixel write-back monitor: count, checksum and ordering checks.
// Checksum adder exists only when LCD_HOST_CKSUM_EN is defined.
module lcd_iram_mon
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run_clr,
  input  logic        pix_clr,
  input  logic        in_wait,
  input  logic        done,
  input  logic        IRAM_valid,
  input  logic [7:0]  IRAM_D,
  input  logic [5:0]  IRAM_A,
  output logic [6:0]  pix_cnt,
  output logic [15:0] checksum,
  output logic        err
);

  localparam logic [6:0] PIX_MAX = 7'(PIX_TOTAL);

  logic bad;

  assign bad = (IRAM_valid &&
                (IRAM_A != pix_cnt[5:0] || !in_wait)) ||
               (done && pix_cnt != PIX_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
      err     <= 1'b0;
    end else if (run_clr) begin
      pix_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (pix_clr)
        pix_cnt <= '0;
      else if (IRAM_valid && pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + 7'd1;
      if (bad)
        err <= 1'b1;
    end
  end

`ifdef LCD_HOST_CKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      checksum <= '0;
    else if (run_clr)
      checksum <= '0;
    else if (IRAM_valid)
      checksum <= checksum + {8'h00, IRAM_D};
  end
`else
  logic unused_d;
  assign unused_d = ^IRAM_D;
  assign checksum = '0;
`endif

endmodule

// File: rtl/lcd_host_seq.sv
// LCD host sequencer: fetches commands from ROM and issues them.
// Optional pixel checksum enabled by LCD_HOST_CKSUM_EN.
module lcd_host_seq
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_cmds,
  output logic        CROM_rd,
  output logic [7:0]  CROM_A,
  input  logic [3:0]  CROM_Q,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        done,
  input  logic        IRAM_valid,
  input  logic [7:0]  IRAM_D,
  input  logic [5:0]  IRAM_A,
  output logic        finish,
  output logic        err,
  output logic [6:0]  pix_cnt,
  output logic [15:0] checksum
);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] n_q;
  logic       last;
  logic       run_clr;

  assign last      = (cnt == n_q);
  assign run_clr   = (state == IDLE) && start;
  assign cmd_valid = (state == ISSUE) && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      n_q     <= '0;
      CROM_rd <= 1'b0;
      CROM_A  <= '0;
      cmd     <= '0;
      finish  <= 1'b0;
    end else begin
      CROM_rd <= 1'b0;
      finish  <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          cnt <= '0;
          n_q <= num_cmds;
          if (num_cmds == 8'd0) begin
            state  <= FINISH;
            finish <= 1'b1;
          end else begin
            state   <= FETCH;
            CROM_rd <= 1'b1;
            CROM_A  <= 8'd0;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          cmd   <= CROM_Q;
          state <= ISSUE;
        end
        ISSUE: if (!busy) begin
          cnt   <= cnt + 8'd1;
          state <= GAP;
        end
        GAP, WAIT_DONE: begin
          // A write command must see its pixel stream and done first
          if (state == GAP && cmd == CMD_WRITE) begin
            state <= WAIT_DONE;
          end else if (state == GAP || done) begin
            if (last) begin
              state  <= FINISH;
              finish <= 1'b1;
            end else begin
              state   <= FETCH;
              CROM_rd <= 1'b1;
              CROM_A  <= cnt;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lcd_iram_mon u_mon (
    .clk        (clk),
    .reset      (reset),
    .run_clr    (run_clr),
    .pix_clr    (cmd_valid && cmd == CMD_WRITE),
    .in_wait    (state == WAIT_DONE),
    .done       (done),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .pix_cnt    (pix_cnt),
    .checksum   (checksum),
    .err        (err)
  );

endmodule

// File: tb/tb_lcd_host_seq.sv
// Bench for lcd_host_seq: ROM/LCD emulation plus a transaction model.
// Directed runs cover writes, busy stalls, errors, 255 cmds, reset.
module tb_lcd_host_seq;

`ifdef LCD_HOST_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [7:0]  num_cmds = 0;
  logic        CROM_rd;
  logic [7:0]  CROM_A;
  logic [3:0]  CROM_Q = 0;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy = 0;
  logic        done = 0;
  logic        IRAM_valid = 0;
  logic [7:0]  IRAM_D = 0;
  logic [5:0]  IRAM_A = 0;
  logic        finish;
  logic        err;
  logic [6:0]  pix_cnt;
  logic [15:0] checksum;

  lcd_host_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_cmds(num_cmds),
    .CROM_rd(CROM_rd), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .finish(finish), .err(err), .pix_cnt(pix_cnt),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int tot_n = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  logic [3:0] rom [256];
  int  cmd_q[$];
  int  m_pix = 0, m_sum = 0, m_addr = 0;
  bit  m_err = 0, m_in_wait = 0, m_run = 0, prev_cv = 0;
  bit  busy_mode = 0;
  int  bcnt = 0;

  // command ROM: data one cycle after the read strobe
  always @(posedge clk) begin
    logic       rd;
    logic [7:0] a;
    rd = CROM_rd;
    a  = CROM_A;
    #1;
    if (rd) CROM_Q = rom[a];
  end

  // LCD controller goes busy for 10 cycles after each command
  always @(negedge clk) if (cmd_valid) bcnt = 10;
  always @(posedge clk) begin
    #1;
    if (busy_mode && bcnt > 0) begin
      busy = 1;
      bcnt--;
    end else begin
      busy = 0;
    end
  end

  // model and compare on every falling edge
  always @(negedge clk) begin
    bit clr;
    int e;
    clr = 0;
    if (reset) begin
      chk("reset_outs", {CROM_rd, CROM_A, cmd, cmd_valid, finish,
                         err, pix_cnt, checksum}, 64'd0);
      m_pix = 0; m_sum = 0; m_err = 0; m_run = 0; prev_cv = 0;
    end else begin
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", 1, 0);
        end else begin
          e = cmd_q.pop_front();
          chk("cmd", cmd, e);
          if (e == 0) clr = 1;
        end
        chk("busy_at_valid", busy, 0);
        chk("cv_one_cycle", prev_cv, 0);
      end
      prev_cv = cmd_valid;
      if (CROM_rd) begin
        chk("crom_a", CROM_A, m_addr);
        m_addr++;
      end
      chk("pix_cnt", pix_cnt, m_pix);
      chk("checksum", checksum, CK ? m_sum : 0);
      chk("err", err, m_err);
      if (start && !m_run) begin
        m_pix = 0; m_sum = 0; m_err = 0;
      end else begin
        if (IRAM_valid) begin
          if (IRAM_A != 6'(m_pix) || !m_in_wait) m_err = 1;
          m_sum = (m_sum + int'(IRAM_D)) % 65536;
        end
        if (done && m_pix != 64) m_err = 1;
        if (clr) m_pix = 0;
        else if (IRAM_valid && m_pix < 64) m_pix++;
      end
    end
  end

  task automatic do_pix(input int bad, input bit last);
    @(posedge clk);
    @(posedge clk);
    #1;
    m_in_wait = 1;
    for (int i = 0; i < 64; i++) begin
      IRAM_valid = 1;
      IRAM_A = (i == bad) ? 6'd5 : 6'(i);
      IRAM_D = 8'(i);
      @(posedge clk);
      #1;
    end
    IRAM_valid = 0;
    done = 1;
    @(posedge clk);
    #1;
    done = 0;
    m_in_wait = 0;
    @(negedge clk);
    chk(last ? "finish_after_done" : "no_early_finish", finish, last);
  endtask

  task automatic run(input int n, input int bad);
    int  seen, cyc;
    bit  fin;
    cmd_q.delete();
    for (int i = 0; i < n; i++) cmd_q.push_back(int'(rom[i]));
    m_addr = 0;
    @(posedge clk);
    #1;
    start = 1;
    num_cmds = 8'(n);
    @(posedge clk);
    #1;
    start = 0;
    m_run = 1;
    seen = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cmd_valid) begin
        seen++;
        if (cmd == 0) do_pix(bad, seen == n);
      end
      if (finish) fin = 1;
    end
    m_run = 0;
    chk("finish_seen", fin, 1);
    if (n == 0) chk("finish_latency", cyc, 1);
    chk("cmds_left", cmd_q.size(), 0);
    chk("rom_reads", m_addr, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix", pix_cnt, 0);
    chk("rst_err", err, 0);
    reset = 0;

    rom[0] = 4'd0;
    run(1, -1);
    chk("w1_pix", pix_cnt, 64);
    chk("w1_sum", checksum, CK ? 2016 : 0);
    chk("w1_err", err, 0);

    rom[0] = 4'd0; rom[1] = 4'd0;
    run(2, -1);
    chk("w2_pix", pix_cnt, 64);
    chk("w2_sum", checksum, CK ? 4032 : 0);

    rom[0] = 4'd1; rom[1] = 4'd3; rom[2] = 4'd5; rom[3] = 4'd0;
    busy_mode = 1;
    bcnt = 10;
    run(4, -1);
    busy_mode = 0;
    chk("busy_err", err, 0);

    rom[0] = 4'd0;
    run(1, 4);
    chk("bad_addr_err", err, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);

    run(0, -1);
    chk("n0_err_clr", err, 0);

    for (int i = 0; i < 255; i++) rom[i] = 4'((i % 11) + 1);
    run(255, -1);
    chk("last_addr", CROM_A, 254);

    // reset in WAIT_DONE with a stray start pulse beforehand
    rom[0] = 4'd0;
    cmd_q.delete();
    cmd_q.push_back(0);
    m_addr = 0;
    @(posedge clk);
    #1;
    start = 1;
    num_cmds = 8'd1;
    @(posedge clk);
    #1;
    start = 0;
    m_run = 1;
    k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_run_issue", cmd_valid, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    m_in_wait = 1;
    for (int i = 0; i < 10; i++) begin
      IRAM_valid = 1;
      IRAM_A = 6'(i);
      IRAM_D = 8'(i + 100);
      start = (i == 5);
      num_cmds = 8'd0;
      @(posedge clk);
      #1;
    end
    start = 0;
    @(negedge clk);
    chk("start_ignored_pix", pix_cnt, 10);
    chk("start_ignored_fin", finish, 0);
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("rst_async", {CROM_rd, CROM_A, cmd, cmd_valid, finish,
                      err, pix_cnt, checksum}, 64'd0);
    IRAM_valid = 0;
    m_in_wait = 0;
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    run(1, -1);
    chk("post_rst_pix", pix_cnt, 64);
    chk("post_rst_sum", checksum, CK ? 2016 : 0);
    chk("post_rst_err", err, 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
